// File: rtl/stream_pkg.sv
// stream_pkg: shared types and next-grant logic for the stream matrix arbiter
//   arb_state_t : arbiter FSM states
//   req_id_t    : requester identifier used by the round-robin pointer
//   pick()      : next state from the two valids and the priority pointer
package stream_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT_A, ARB_GRANT_B} arb_state_t;
    typedef enum logic {REQ_A, REQ_B} req_id_t;

    function automatic arb_state_t pick(input logic valid_a, input logic valid_b, input req_id_t ptr);
        return (valid_a && valid_b) ? ((ptr == REQ_A) ? ARB_GRANT_A : ARB_GRANT_B) :
               valid_a ? ARB_GRANT_A :
               valid_b ? ARB_GRANT_B : ARB_IDLE;
    endfunction

endpackage

// File: rtl/stream_len_checker.sv
// stream_len_checker: per-grant element counter with sticky matrix length error
//   clk, rst_n : clock, asynchronous active-low reset
//   xfer       : an element transferred on the output bus this cycle
//   last       : the transferred element is flagged last
//   clr        : synchronous clear of len_err (a simultaneous set wins)
//   len_err    : sticky error, last at the wrong position or MATRIX_LEN elements without last
module stream_len_checker #(
    parameter int MATRIX_LEN = 55
) (
    input  logic clk,
    input  logic rst_n,
    input  logic xfer,
    input  logic last,
    input  logic clr,
    output logic len_err
);

    localparam int CW = $clog2(MATRIX_LEN + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(MATRIX_LEN - 1);
    localparam logic [CW-1:0] FULL = CW'(MATRIX_LEN);

    logic [CW-1:0] cnt;
    logic set;

    // cnt holds the index of the next element; a grant always starts after a last or a reset, so it starts at 0
    assign set = xfer && (last ? (cnt != LAST_IDX) : (cnt == LAST_IDX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            len_err <= 1'b0;
        end else begin
            cnt <= !xfer ? cnt : last ? '0 : (cnt == FULL) ? cnt : cnt + 1'b1;
            len_err <= set | (len_err & ~clr);
        end
    end

endmodule

// File: rtl/stream_matrix_arbiter.sv
// stream_matrix_arbiter: matrix-granular round-robin arbiter sharing one stream bus between A and B
//   clk, rst_n              : clock, asynchronous active-low reset
//   ds_in_{a,b}_next_data   : ready back to each requester
//   ds_in_{a,b}_out/valid/last : requester streams
//   ds_out_next_data        : downstream ready
//   ds_out/valid/last       : muxed stream from the current owner
//   grant_a, grant_b        : current owner from the state register
//   done_a, done_b          : one-cycle pulse after that requester's last element transferred
//   len_err, len_err_clr    : sticky length error and its clear, active only with
//                             STREAM_MATRIX_ARBITER_LEN_CHECK_EN defined, otherwise len_err = 0
module stream_matrix_arbiter
    import stream_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MATRIX_LEN = 55
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             ds_in_a_next_data,
    input  logic [WIDTH-1:0] ds_in_a_out,
    input  logic             ds_in_a_valid,
    input  logic             ds_in_a_last,
    output logic             ds_in_b_next_data,
    input  logic [WIDTH-1:0] ds_in_b_out,
    input  logic             ds_in_b_valid,
    input  logic             ds_in_b_last,
    input  logic             ds_out_next_data,
    output logic [WIDTH-1:0] ds_out,
    output logic             ds_out_valid,
    output logic             ds_out_last,
    output logic             grant_a,
    output logic             grant_b,
    output logic             done_a,
    output logic             done_b,
    output logic             len_err,
    input  logic             len_err_clr
);

    arb_state_t state, state_nxt;
    req_id_t ptr;
    logic last_a, last_b;

    assign grant_a = (state == ARB_GRANT_A);
    assign grant_b = (state == ARB_GRANT_B);
    assign last_a = grant_a && ds_in_a_valid && ds_out_next_data && ds_in_a_last;
    assign last_b = grant_b && ds_in_b_valid && ds_out_next_data && ds_in_b_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
            ptr <= REQ_A;
            done_a <= 1'b0;
            done_b <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr <= last_a ? REQ_B : last_b ? REQ_A : ptr;
            done_a <= last_a;
            done_b <= last_b;
        end
    end

    // on a last transfer the other requester gets priority, so a waiting peer is granted with no bubble
    always_comb begin
        state_nxt = (state == ARB_IDLE) ? pick(ds_in_a_valid, ds_in_b_valid, ptr) :
                    last_a ? pick(ds_in_a_valid, ds_in_b_valid, REQ_B) :
                    last_b ? pick(ds_in_a_valid, ds_in_b_valid, REQ_A) : state;
    end

    always_comb begin
        ds_out = grant_a ? ds_in_a_out : grant_b ? ds_in_b_out : '0;
        ds_out_valid = grant_a ? ds_in_a_valid : grant_b && ds_in_b_valid;
        ds_out_last = grant_a ? ds_in_a_last : grant_b && ds_in_b_last;
        ds_in_a_next_data = grant_a && ds_out_next_data;
        ds_in_b_next_data = grant_b && ds_out_next_data;
    end

`ifdef STREAM_MATRIX_ARBITER_LEN_CHECK_EN
    stream_len_checker #(.MATRIX_LEN(MATRIX_LEN)) u_len_checker (
        .clk     (clk),
        .rst_n   (rst_n),
        .xfer    (ds_out_valid && ds_out_next_data),
        .last    (ds_out_last),
        .clr     (len_err_clr),
        .len_err (len_err)
    );
`else
    logic unused_cfg;
    assign unused_cfg = len_err_clr ^ (MATRIX_LEN > 0);
    assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_stream_matrix_arbiter.sv
// tb_stream_matrix_arbiter: directed self-checking bench for stream_matrix_arbiter (MATRIX_LEN = 4)
module tb_stream_matrix_arbiter;

    logic        clk, rst_n;
    logic        ds_in_a_next_data, ds_in_b_next_data;
    logic [31:0] ds_in_a_out, ds_in_b_out, ds_out;
    logic        ds_in_a_valid, ds_in_a_last, ds_in_b_valid, ds_in_b_last;
    logic        ds_out_next_data, ds_out_valid, ds_out_last;
    logic        grant_a, grant_b, done_a, done_b, len_err, len_err_clr;

    stream_matrix_arbiter #(.WIDTH(32), .MATRIX_LEN(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ds_in_a_next_data (ds_in_a_next_data),
        .ds_in_a_out       (ds_in_a_out),
        .ds_in_a_valid     (ds_in_a_valid),
        .ds_in_a_last      (ds_in_a_last),
        .ds_in_b_next_data (ds_in_b_next_data),
        .ds_in_b_out       (ds_in_b_out),
        .ds_in_b_valid     (ds_in_b_valid),
        .ds_in_b_last      (ds_in_b_last),
        .ds_out_next_data  (ds_out_next_data),
        .ds_out            (ds_out),
        .ds_out_valid      (ds_out_valid),
        .ds_out_last       (ds_out_last),
        .grant_a           (grant_a),
        .grant_b           (grant_b),
        .done_a            (done_a),
        .done_b            (done_b),
        .len_err           (len_err),
        .len_err_clr       (len_err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [31:0] qa_d[$], qb_d[$], od[$], ed[$];
    bit          qa_l[$], qb_l[$], ol[$], el[$];
    int first_x, last_x, n_x, n_da, n_db, b_start;
    bit gap_a, rnd_ready, a_last_done, b_early, both_rdy, b_rdy_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] elem(input bit side, input int m, input int i);
        return (side ? 32'hB000_0000 : 32'hA000_0000) | (32'(m) << 8) | 32'(i);
    endfunction

    task automatic push_src(input bit side, input int m, input int n);
        for (int i = 0; i < n; i++) begin
            if (side) begin qb_d.push_back(elem(side, m, i)); qb_l.push_back(i == n - 1); end
            else begin qa_d.push_back(elem(side, m, i)); qa_l.push_back(i == n - 1); end
        end
    endtask

    task automatic push_exp(input bit side, input int m, input int n);
        for (int i = 0; i < n; i++) begin
            ed.push_back(elem(side, m, i));
            el.push_back(i == n - 1);
        end
    endtask

    task automatic idle_inputs();
        ds_in_a_valid = 0; ds_in_a_out = '0; ds_in_a_last = 0;
        ds_in_b_valid = 0; ds_in_b_out = '0; ds_in_b_last = 0;
        ds_out_next_data = 0; len_err_clr = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        idle_inputs();
        qa_d.delete(); qa_l.delete(); qb_d.delete(); qb_l.delete();
        od.delete(); ol.delete(); ed.delete(); el.delete();
        gap_a = 0; rnd_ready = 0; b_start = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic run(input int ncyc);
        bit pa, pb;
        first_x = -1; last_x = -1; n_x = 0; n_da = 0; n_db = 0;
        a_last_done = 0; b_early = 0; both_rdy = 0; b_rdy_seen = 0;
        for (int c = 0; c < ncyc; c++) begin
            ds_in_a_valid = (qa_d.size() > 0) && !(gap_a && (c % 3 == 1));
            ds_in_a_out = (qa_d.size() > 0) ? qa_d[0] : '0;
            ds_in_a_last = (qa_l.size() > 0) ? qa_l[0] : 1'b0;
            ds_in_b_valid = (qb_d.size() > 0) && (c >= b_start);
            ds_in_b_out = (qb_d.size() > 0) ? qb_d[0] : '0;
            ds_in_b_last = (qb_l.size() > 0) ? qb_l[0] : 1'b0;
            ds_out_next_data = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #4;
            if (ds_out_valid && ds_out_next_data) begin
                od.push_back(ds_out); ol.push_back(ds_out_last);
                if (first_x < 0) first_x = c;
                last_x = c; n_x++;
            end
            pa = ds_in_a_valid && ds_in_a_next_data;
            pb = ds_in_b_valid && ds_in_b_next_data;
            if (done_a) n_da++;
            if (done_b) n_db++;
            if (ds_in_b_next_data) b_rdy_seen = 1;
            if (ds_in_b_next_data && !a_last_done) b_early = 1;
            if (ds_in_a_next_data && ds_in_b_next_data) both_rdy = 1;
            if (pa && ds_in_a_last) a_last_done = 1;
            @(posedge clk);
            #1;
            if (pa) begin void'(qa_d.pop_front()); void'(qa_l.pop_front()); end
            if (pb) begin void'(qb_d.pop_front()); void'(qb_l.pop_front()); end
        end
    endtask

    task automatic check_seq(input string tag);
        chk({tag, "_count"}, od.size(), ed.size());
        for (int i = 0; i < od.size() && i < ed.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), od[i], ed[i]);
            chk($sformatf("%s_last%0d", tag, i), 32'(ol[i]), 32'(el[i]));
        end
    endtask

    initial begin
        do_reset();
        chk("rst_grant_a", grant_a, 0);
        chk("rst_grant_b", grant_b, 0);
        chk("rst_valid", ds_out_valid, 0);
        chk("rst_done", {done_a, done_b}, 0);
        chk("rst_len_err", len_err, 0);

        // only A, three back-to-back matrices, always ready
        push_src(0, 0, 4); push_src(0, 1, 4); push_src(0, 2, 4);
        push_exp(0, 0, 4); push_exp(0, 1, 4); push_exp(0, 2, 4);
        run(20);
        chk("t1_first_xfer", first_x, 1);
        chk("t1_last_xfer", last_x, 12);
        chk("t1_n_xfer", n_x, 12);
        chk("t1_done_a", n_da, 3);
        chk("t1_done_b", n_db, 0);
        chk("t1_b_ready", b_rdy_seen, 0);
        check_seq("t1");

        // both valid right after reset: A, B, A, B with no bubble between matrices
        do_reset();
        push_src(0, 0, 4); push_src(0, 1, 4); push_src(1, 0, 4); push_src(1, 1, 4);
        push_exp(0, 0, 4); push_exp(1, 0, 4); push_exp(0, 1, 4); push_exp(1, 1, 4);
        run(24);
        chk("t2_first_xfer", first_x, 1);
        chk("t2_last_xfer", last_x, 16);
        chk("t2_done_a", n_da, 2);
        chk("t2_done_b", n_db, 2);
        chk("t2_both_ready", both_rdy, 0);
        check_seq("t2");
`ifndef STREAM_MATRIX_ARBITER_LEN_CHECK_EN
        chk("t2_len_err_off", len_err, 0);
`endif

        // same traffic with random downstream stalls
        do_reset();
        rnd_ready = 1;
        push_src(0, 0, 4); push_src(0, 1, 4); push_src(1, 0, 4); push_src(1, 1, 4);
        push_exp(0, 0, 4); push_exp(1, 0, 4); push_exp(0, 1, 4); push_exp(1, 1, 4);
        run(150);
        chk("t3_both_ready", both_rdy, 0);
        chk("t3_done_a", n_da, 2);
        chk("t3_done_b", n_db, 2);
        check_seq("t3");

        // B arrives mid A-matrix while A has valid gaps
        do_reset();
        gap_a = 1; b_start = 2;
        push_src(0, 0, 4); push_src(1, 0, 4);
        push_exp(0, 0, 4); push_exp(1, 0, 4);
        run(20);
        chk("t4_b_held_off", b_early, 0);
        chk("t4_first_xfer", first_x, 2);
        chk("t4_last_xfer", last_x, 10);
        check_seq("t4");

        // reset two elements into A's second matrix (ptr has moved to B by then)
        do_reset();
        push_src(0, 0, 4); push_src(0, 1, 4);
        run(7);
        chk("t5_pre_grant_a", grant_a, 1);
        rst_n = 0;
        #2;
        chk("t5_async_valid", ds_out_valid, 0);
        chk("t5_async_data", ds_out, 0);
        chk("t5_async_grant", {grant_a, grant_b}, 0);
        chk("t5_async_ready", {ds_in_a_next_data, ds_in_b_next_data}, 0);
        do_reset();
        chk("t5_idle_grant", {grant_a, grant_b}, 0);
        push_src(1, 5, 4); push_src(0, 6, 4);
        push_exp(0, 6, 4); push_exp(1, 5, 4);
        run(14);
        chk("t5_first_xfer", first_x, 1);
        check_seq("t5");

`ifdef STREAM_MATRIX_ARBITER_LEN_CHECK_EN
        // short matrix (last at element 3 of 4), then a correct one
        do_reset();
        push_src(0, 0, 3); push_src(0, 1, 4);
        push_exp(0, 0, 3); push_exp(0, 1, 4);
        run(12);
        chk("t6_len_err_set", len_err, 1);
        check_seq("t6");
        len_err_clr = 1;
        @(posedge clk);
        #1 len_err_clr = 0;
        chk("t6_len_err_clr", len_err, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
